// File: rtl/lsr_serial_scheduler_pkg.sv
// Shared types for the shift-register frame scheduler.
// State encoding and counter sizing helpers.
package lsr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    function automatic int cnt_w(input int bits);
        return $clog2(bits + 1);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lsr_serial_scheduler_if.sv
// Word handshake between producer and scheduler.
// Producer drives data/valid, scheduler returns ready.
interface lsr_serial_scheduler_if #(
    parameter int BITS = 8
);

    logic [BITS-1:0] s_data;
    logic            s_valid;
    logic            s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/lsr_serial_scheduler_down_counter.sv
// Loadable down-counter with zero/last flags.
// Shared between shift bit count and inter-frame gap.
module lsr_down_counter #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         last
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/lsr_serial_scheduler.sv
// Sequences one load plus BITS shift cycles per accepted word,
// followed by a programmable idle gap.
module lsr_serial_scheduler
    import lsr_ctrl_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int GAP_W  = 4,
    parameter int FCNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    lsr_serial_scheduler_if.slave s,
    input  logic [GAP_W-1:0]  gap_cfg,
    input  logic              fill_bit,
    output logic [BITS-1:0]   lsr_data,
    output logic              lsr_load,
    output logic              lsr_in,
    output logic              bit_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count
);

    // Counter must hold both BITS and the largest gap value.
    localparam int CW = max_i(cnt_w(BITS), GAP_W);

    state_t            state;
    state_t            state_d;
    logic              accept;
    logic              shift_end;
    logic [GAP_W-1:0]  gap_q;
    logic              cnt_load;
    logic [CW-1:0]     cnt_val;
    logic              cnt_dec;
    logic [CW-1:0]     cnt;
    logic              cnt_zero;
    logic              cnt_last;

    assign s.s_ready = (state == IDLE) && enable && RST;
    assign accept    = s.s_valid && s.s_ready;

    lsr_down_counter #(
        .W (CW)
    ) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .load  (cnt_load),
        .value (cnt_val),
        .dec   (cnt_dec),
        .count (cnt),
        .zero  (cnt_zero),
        .last  (cnt_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        shift_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d  = SHIFT;
                cnt_load = 1'b1;
                cnt_val  = CW'(BITS);
            end
            SHIFT: begin
                if (cnt_last) begin
                    shift_end = 1'b1;
                    if (gap_q != '0) begin
                        state_d  = GAP;
                        cnt_load = 1'b1;
                        cnt_val  = CW'(gap_q);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (cnt_last || cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lsr_data    <= '0;
            lsr_in      <= 1'b0;
            gap_q       <= '0;
            lsr_load    <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            lsr_load   <= accept;
            bit_valid  <= (state_d == SHIFT);
            busy       <= (state_d != IDLE);
            frame_done <= shift_end;
            if (shift_end) begin
                frame_count <= frame_count + 1'b1;
            end
            if (accept) begin
                lsr_data <= s.s_data;
                lsr_in   <= fill_bit;
                gap_q    <= gap_cfg;
            end
        end
    end

endmodule

// File: tb/tb_lsr_serial_scheduler.sv
// Bench for lsr_serial_scheduler: vector table, corner sequences
// and random traffic against a frame-timing reference model.
module tb_lsr_serial_scheduler;

    localparam int BITS  = 8;
    localparam int GAP_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             enable = 1'b0;
    logic             fill_bit = 1'b0;
    logic [GAP_W-1:0] gap_cfg = '0;

    logic [BITS-1:0]  lsr_data, lsr_data2;
    logic             lsr_load, lsr_load2;
    logic             lsr_in, lsr_in2;
    logic             bit_valid, bit_valid2;
    logic             busy, busy2;
    logic             frame_done, frame_done2;
    logic [15:0]      frame_count;
    logic [1:0]       frame_count2;

    lsr_serial_scheduler_if #(.BITS(BITS)) sif ();
    lsr_serial_scheduler_if #(.BITS(BITS)) sif2 ();

    always #5 CLK = ~CLK;

    lsr_serial_scheduler #(
        .BITS(BITS), .GAP_W(GAP_W), .FCNT_W(16)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .s(sif),
        .gap_cfg(gap_cfg), .fill_bit(fill_bit),
        .lsr_data(lsr_data), .lsr_load(lsr_load), .lsr_in(lsr_in),
        .bit_valid(bit_valid), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    lsr_serial_scheduler #(
        .BITS(BITS), .GAP_W(GAP_W), .FCNT_W(2)
    ) dut2 (
        .CLK(CLK), .RST(RST), .enable(enable), .s(sif2),
        .gap_cfg(gap_cfg), .fill_bit(fill_bit),
        .lsr_data(lsr_data2), .lsr_load(lsr_load2), .lsr_in(lsr_in2),
        .bit_valid(bit_valid2), .busy(busy2), .frame_done(frame_done2),
        .frame_count(frame_count2)
    );

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    // reference model: frame described by the cycle it was accepted in
    bit        m_active = 0;
    int        m_acc = 0;
    int        m_gap = 0;
    logic [7:0] m_data = '0;
    logic      m_in = 1'b0;
    int        m_cnt = 0;

    logic       sn_ready, sn_load, sn_bv, sn_done, sn_busy;
    logic [7:0] sn_data;
    logic [15:0] sn_cnt;
    logic [1:0] sn_cnt2;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        sif.s_valid  = v;
        sif.s_data   = d;
        sif2.s_valid = v;
        sif2.s_data  = d;
    endtask

    task automatic model_cycle();
        int   d;
        logic e_ready, e_load, e_bv, e_done, e_busy;
        cyc++;
        sn_ready = sif.s_ready;
        sn_load  = lsr_load;
        sn_bv    = bit_valid;
        sn_done  = frame_done;
        sn_busy  = busy;
        sn_data  = lsr_data;
        sn_cnt   = frame_count;
        sn_cnt2  = frame_count2;
        if (!RST) begin
            m_active = 0;
            m_cnt    = 0;
            m_data   = '0;
            m_in     = 1'b0;
            e_ready = 0; e_load = 0; e_bv = 0; e_done = 0; e_busy = 0;
        end else begin
            d = cyc - m_acc;
            if (m_active && d == BITS + 2) m_cnt++;
            e_load  = m_active && d == 1;
            e_bv    = m_active && d >= 2 && d <= BITS + 1;
            e_done  = m_active && d == BITS + 2;
            e_busy  = m_active && d >= 1 && d < BITS + 2 + m_gap;
            e_ready = enable && !e_busy;
        end
        chk("s_ready", sif.s_ready, e_ready);
        chk("lsr_load", lsr_load, e_load);
        chk("bit_valid", bit_valid, e_bv);
        chk("frame_done", frame_done, e_done);
        chk("busy", busy, e_busy);
        chk("lsr_data", lsr_data, m_data);
        chk("lsr_in", lsr_in, m_in);
        chk("frame_count", frame_count, m_cnt & 'hFFFF);
        chk("frame_count_w2", frame_count2, m_cnt & 3);
        chk("dut2_outs",
            {sif2.s_ready, lsr_load2, bit_valid2, frame_done2, busy2,
             lsr_in2, lsr_data2},
            {e_ready, e_load, e_bv, e_done, e_busy, m_in, m_data});
        if (RST && sif.s_valid && e_ready) begin
            m_active = 1;
            m_acc    = cyc;
            m_gap    = int'(gap_cfg);
            m_data   = sif.s_data;
            m_in     = fill_bit;
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        model_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, 8'h00);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic spacing(input logic [3:0] g, input int exp);
        int loads[$];
        gap_cfg = g;
        drive(1'b1, 8'hC3);
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (sn_load) loads.push_back(i);
        end
        if (loads.size() < 2) chk("spacing_loads", loads.size(), 2);
        else chk("spacing", loads[1] - loads[0], exp);
        idle_cycles(25);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       f;
        logic [3:0] g;
        logic       rdy, ld, bv, dn, bz;
        logic [7:0] data;
        int         cnt;
    } vec_t;

    vec_t tv[23];
    int   exp6[5];

    initial begin
        int nbv, ndone, nload, nready, nbusy, cnt2;

        // single frame with gap 0, then a second with gap 1
        tv[0]  = '{1, 8'hA5, 1, 0, 1, 0, 0, 0, 0, 8'h00, 0};
        tv[1]  = '{0, 8'hFF, 0, 7, 0, 1, 0, 0, 1, 8'hA5, 0};
        for (int i = 2; i <= 9; i++)
            tv[i] = '{0, 8'hFF, 0, 7, 0, 0, 1, 0, 1, 8'hA5, 0};
        tv[10] = '{0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 8'hA5, 1};
        tv[11] = '{1, 8'h5A, 0, 1, 1, 0, 0, 0, 0, 8'hA5, 1};
        tv[12] = '{0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 8'h5A, 1};
        for (int i = 13; i <= 20; i++)
            tv[i] = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 8'h5A, 1};
        tv[21] = '{0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h5A, 2};
        tv[22] = '{0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h5A, 2};
        exp6 = '{1, 2, 3, 0, 1};

        // reset holds ready low even with valid and enable
        enable = 1'b1;
        drive(1'b1, 8'h11);
        cycle();
        cycle();
        chk("rst_ready", sn_ready, 0);
        chk("rst_outs", {sn_load, sn_bv, sn_done, sn_busy, sn_data},
            13'h0);
        RST = 1'b1;
        drive(1'b0, 8'h11);
        cycle();
        chk("rst_release_ready", sn_ready, 1);

        for (int i = 0; i < 23; i++) begin
            drive(tv[i].v, tv[i].d);
            fill_bit = tv[i].f;
            gap_cfg  = tv[i].g;
            cycle();
            chk($sformatf("tv%0d_ready", i), sn_ready, tv[i].rdy);
            chk($sformatf("tv%0d_outs", i),
                {sn_load, sn_bv, sn_done, sn_busy},
                {tv[i].ld, tv[i].bv, tv[i].dn, tv[i].bz});
            chk($sformatf("tv%0d_data", i), sn_data, tv[i].data);
            chk($sformatf("tv%0d_cnt", i), sn_cnt, tv[i].cnt);
        end

        spacing(4'd3, 13);
        spacing(4'd0, 10);

        // enable dropped in the third shift cycle
        gap_cfg = 4'd0;
        drive(1'b1, 8'h77);
        cycle();
        nbv = 0; ndone = 0; nload = 0; nready = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 4) enable = 1'b0;
            cycle();
            nbv   += int'(sn_bv);
            ndone += int'(sn_done);
            nload += int'(sn_load);
            if (i >= 4) nready += int'(sn_ready);
        end
        chk("en_drop_bits", nbv, BITS);
        chk("en_drop_done", ndone, 1);
        chk("en_drop_loads", nload, 1);
        chk("en_drop_ready", nready, 0);
        enable = 1'b1;
        cycle();
        chk("en_restore_ready", sn_ready, 1);
        idle_cycles(25);

        // reset in the fourth shift cycle aborts the frame
        drive(1'b1, 8'hA5);
        cycle();
        drive(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cycle();
        RST = 1'b0;
        cycle();
        chk("rst_mid_outs",
            {sn_load, sn_bv, sn_done, sn_busy, sn_data, sn_cnt}, 0);
        RST = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            ndone += int'(sn_done);
        end
        chk("rst_mid_no_done", ndone, 0);
        drive(1'b1, 8'h3C);
        cycle();
        drive(1'b0, 8'h00);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (i == 1) chk("post_rst_load", {sn_load, sn_data}, 9'h13C);
            if (i == 10) chk("post_rst_done", {sn_done, sn_cnt}, 17'h10001);
        end

        // narrow counter wraps; mid-frame gap change waits a frame
        RST = 1'b0;
        cycle();
        RST = 1'b1;
        for (int f = 0; f < 5; f++) begin
            gap_cfg = 4'd2;
            drive(1'b1, 8'($urandom));
            cycle();
            drive(1'b0, 8'h00);
            if (f == 4) gap_cfg = 4'd9;
            cnt2 = -1; nbusy = 0;
            for (int i = 0; i < 20; i++) begin
                cycle();
                nbusy += int'(sn_busy);
                if (sn_done) cnt2 = int'(sn_cnt2);
            end
            chk($sformatf("wrap_f%0d", f), cnt2, exp6[f]);
            if (f == 4) chk("gap_unchanged", nbusy, BITS + 3);
        end

        for (int i = 0; i < 1500; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 2) != 0, 8'($urandom));
            gap_cfg  = ($urandom_range(0, 4) == 0) ?
                       4'($urandom) : 4'($urandom_range(0, 2));
            fill_bit = 1'($urandom);
            RST      = ($urandom_range(0, 99) != 0);
            cycle();
        end

        RST = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
